// File: rtl/wb_pkg.sv
// wb_pkg: shared widths and types for the register writeback stage
package wb_pkg;
  localparam int DATA_WIDTH   = 32;
  localparam int REG_OP_WIDTH = 5;
  localparam int REG_CNT      = 32;
  localparam int STARVE_LIMIT = 3;
  typedef logic [REG_OP_WIDTH-1:0] reg_idx_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef struct packed {
    reg_idx_t rd;
    data_t    data;
  } wb_req_t;
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: per-register pending bits, issue gating and busy/bypass lookups (bypass lookup enabled by REG_WRITEBACK_BYPASS_EN)
module wb_scoreboard
  import wb_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     i_iss_valid,
  input  reg_idx_t i_iss_rd,
  output logic     o_iss_ready,
  input  logic     i_wen,
  input  reg_idx_t i_wrd,
  input  reg_idx_t i_rs1,
  input  reg_idx_t i_rs2,
  output logic     o_busy1,
  output logic     o_busy2,
  output logic     o_fwd1_valid,
  output logic     o_fwd2_valid
);
  logic [REG_CNT-1:0] r_pending;
  logic [REG_CNT-1:0] w_set;
  logic [REG_CNT-1:0] w_clr;
  assign o_iss_ready = !rst && !r_pending[i_iss_rd];
  assign w_set = (i_iss_valid && o_iss_ready && i_iss_rd != '0) ? REG_CNT'(1) << i_iss_rd : '0;
  assign w_clr = i_wen ? REG_CNT'(1) << i_wrd : '0;
`ifdef REG_WRITEBACK_BYPASS_EN
  assign o_fwd1_valid = i_wen && i_wrd == i_rs1 && i_rs1 != '0;
  assign o_fwd2_valid = i_wen && i_wrd == i_rs2 && i_rs2 != '0;
`else
  assign o_fwd1_valid = 1'b0;
  assign o_fwd2_valid = 1'b0;
`endif
  assign o_busy1 = r_pending[i_rs1] && !o_fwd1_valid;
  assign o_busy2 = r_pending[i_rs2] && !o_fwd2_valid;
  // retiring write clears first so a same-cycle issue of that register stays pending
  always_ff @(posedge clk) begin
    if (rst) r_pending <= '0;
    else r_pending <= (r_pending & ~w_clr) | w_set;
  end
endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: arbitrates ALU/LSU results into one registered RF write per cycle; REG_WRITEBACK_BYPASS_EN adds operand bypass
module reg_writeback
  import wb_pkg::*;
#(
  parameter int STARVE_LIMIT = wb_pkg::STARVE_LIMIT
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     iss_valid,
  input  reg_idx_t iss_rd,
  output logic     iss_ready,
  input  logic     alu_valid,
  output logic     alu_ready,
  input  reg_idx_t alu_rd,
  input  data_t    alu_data,
  input  logic     lsu_valid,
  output logic     lsu_ready,
  input  reg_idx_t lsu_rd,
  input  data_t    lsu_data,
  output logic     rf_wen,
  output reg_idx_t rf_rd,
  output data_t    rf_wdata,
  input  reg_idx_t rs1,
  input  reg_idx_t rs2,
  output logic     busy1,
  output logic     busy2,
  output logic     fwd1_valid,
  output data_t    fwd1_data,
  output logic     fwd2_valid,
  output data_t    fwd2_data
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] r_starve_cnt;
  logic          r_wen;
  wb_req_t       r_out;
  wb_req_t       w_sel;
  logic          w_starve;
  logic          w_alu_acc;
  logic          w_lsu_acc;
  assign w_starve  = r_starve_cnt == CW'(STARVE_LIMIT);
  assign alu_ready = !reset && (!lsu_valid || w_starve);
  assign lsu_ready = !reset && !(w_starve && alu_valid);
  assign w_alu_acc = alu_valid && alu_ready;
  assign w_lsu_acc = lsu_valid && lsu_ready;
  // at most one producer is accepted per cycle, so a plain mux suffices
  always_comb w_sel = w_lsu_acc ? '{lsu_rd, lsu_data} : '{alu_rd, alu_data};
  // count consecutive ALU denials, saturating at the limit that forces an ALU win
  always_ff @(posedge clock) begin
    if (reset || w_alu_acc) r_starve_cnt <= '0;
    else if (alu_valid && !w_starve) r_starve_cnt <= r_starve_cnt + CW'(1);
  end
  // output register: rd 0 results are absorbed without raising the write enable
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wen <= 1'b0;
      r_out <= '0;
    end else begin
      r_wen <= (w_alu_acc || w_lsu_acc) && w_sel.rd != '0;
      if (w_alu_acc || w_lsu_acc) r_out <= w_sel;
    end
  end
  assign rf_wen   = r_wen;
  assign rf_rd    = r_out.rd;
  assign rf_wdata = r_out.data;
`ifdef REG_WRITEBACK_BYPASS_EN
  assign fwd1_data = r_out.data;
  assign fwd2_data = r_out.data;
`else
  assign fwd1_data = '0;
  assign fwd2_data = '0;
`endif
  wb_scoreboard u_sb (
    .clk         (clock),
    .rst         (reset),
    .i_iss_valid (iss_valid),
    .i_iss_rd    (iss_rd),
    .o_iss_ready (iss_ready),
    .i_wen       (r_wen),
    .i_wrd       (r_out.rd),
    .i_rs1       (rs1),
    .i_rs2       (rs2),
    .o_busy1     (busy1),
    .o_busy2     (busy2),
    .o_fwd1_valid(fwd1_valid),
    .o_fwd2_valid(fwd2_valid)
  );
endmodule
